// File: rtl/mixer_gain_ramp.sv
// Gain-smoothing controller: walks each channel's applied gain toward its target by a
// bounded step, one channel per clock, in a round-robin sweep started by the sample tick.
module mixer_gain_ramp #(
  parameter int unsigned NR_OF_CHANNELS_P = 4,
  parameter int unsigned GAIN_WIDTH_P     = 24,
  parameter int unsigned STEP_WIDTH_P     = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            sample_tick,
  input  logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]   cr_target_gain,
  input  logic [STEP_WIDTH_P-1:0]                         cr_ramp_step,
  input  logic                                            cr_ramp_bypass,
  input  logic                                            cr_clear_overrun,
  output logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]   mix_channel_gain,
  output logic [NR_OF_CHANNELS_P-1:0]                     sr_ramp_busy,
  output logic                                            sr_tick_overrun,
  output logic                                            sweep_done
);

  localparam int unsigned IDX_W = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_OF_CHANNELS_P - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                                          state_q, state_d;
  logic [IDX_W-1:0]                                idx_q, idx_d;
  logic                                            pending_q, pending_d;
  logic                                            overrun_q, overrun_d;
  logic                                            done_q, done_d;
  logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0]   gain_q, gain_d;
  logic                                            overrun_set;
  logic                                            last_chan;

  // Difference is taken one bit wider so the compare against the step never wraps;
  // a full step is only applied when it cannot reach or pass the target.
  function automatic logic [GAIN_WIDTH_P-1:0] ramp_next(
    input logic [GAIN_WIDTH_P-1:0] cur,
    input logic [GAIN_WIDTH_P-1:0] tgt,
    input logic [STEP_WIDTH_P-1:0] step
  );
    logic [GAIN_WIDTH_P:0] diff;
    logic [GAIN_WIDTH_P:0] mag;
    logic [GAIN_WIDTH_P:0] step_x;
    diff   = {tgt[GAIN_WIDTH_P-1], tgt} - {cur[GAIN_WIDTH_P-1], cur};
    mag    = diff[GAIN_WIDTH_P] ? (~diff + 1'b1) : diff;
    step_x = (GAIN_WIDTH_P+1)'(step);
    if (mag <= step_x) begin
      ramp_next = tgt;
    end else if (!diff[GAIN_WIDTH_P]) begin
      ramp_next = cur + GAIN_WIDTH_P'(step);
    end else begin
      ramp_next = cur - GAIN_WIDTH_P'(step);
    end
  endfunction

  assign last_chan = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    overrun_set = 1'b0;
    if (cr_ramp_bypass) begin
      state_d   = IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            state_d = SWEEP;
            idx_d   = '0;
          end
        end
        SWEEP: begin
          if (last_chan) begin
            done_d    = 1'b1;
            idx_d     = '0;
            pending_d = 1'b0;
            state_d   = (pending_q || sample_tick) ? SWEEP : IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (sample_tick) begin
              if (pending_q) begin
                overrun_set = 1'b1;
              end else begin
                pending_d = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    overrun_d = overrun_set | (overrun_q & ~cr_clear_overrun);
  end

  always_comb begin
    gain_d = gain_q;
    if (cr_ramp_bypass) begin
      gain_d = cr_target_gain;
    end else if (state_q == SWEEP) begin
      for (int unsigned i = 0; i < NR_OF_CHANNELS_P; i++) begin
        if (idx_q == IDX_W'(i)) begin
          gain_d[i] = ramp_next(gain_q[i], cr_target_gain[i], cr_ramp_step);
        end
      end
    end
  end

  always_comb begin
    sr_ramp_busy = '0;
    for (int unsigned i = 0; i < NR_OF_CHANNELS_P; i++) begin
      sr_ramp_busy[i] = (gain_q[i] != cr_target_gain[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      gain_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      gain_q    <= gain_d;
    end
  end

  assign mix_channel_gain = gain_q;
  assign sr_tick_overrun  = overrun_q;
  assign sweep_done       = done_q;

endmodule

// File: tb/tb_mixer_gain_ramp.sv
// Directed bench for mixer_gain_ramp: ramp arithmetic, sweep timing, overrun and bypass.
module tb_mixer_gain_ramp;

  localparam int unsigned N  = 4;
  localparam int unsigned GW = 24;
  localparam int unsigned SW = 20;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sample_tick;
  logic [N-1:0][GW-1:0] tgt;
  logic [SW-1:0]        step;
  logic                 bypass;
  logic                 clr;
  logic [N-1:0][GW-1:0] gain;
  logic [N-1:0]         busy;
  logic                 overrun;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mixer_gain_ramp #(
    .NR_OF_CHANNELS_P(N),
    .GAIN_WIDTH_P    (GW),
    .STEP_WIDTH_P    (SW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_tick      (sample_tick),
    .cr_target_gain   (tgt),
    .cr_ramp_step     (step),
    .cr_ramp_bypass   (bypass),
    .cr_clear_overrun (clr),
    .mix_channel_gain (gain),
    .sr_ramp_busy     (busy),
    .sr_tick_overrun  (overrun),
    .sweep_done       (done)
  );

  task automatic nclk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_tick = 1'b0; bypass = 1'b0; clr = 1'b0;
    step = 20'h40000;
    tgt[0] = 24'h100000; tgt[1] = 24'hF00000; tgt[2] = 24'h000000; tgt[3] = 24'h7FFFFF;
    nclk(2);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gain[i] !== 24'h0) begin
        failures++; $display("FAIL reset_gain%0d got=%h exp=000000", i, gain[i]);
      end
    end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++;
    if (busy !== 4'b1011) begin failures++; $display("FAIL reset_busy got=%b exp=1011", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    int dones = 0;
    for (int t = 1; t <= 32; t++) begin
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (15) begin
        @(negedge clk);
        if (done) dones++;
      end
      if (t == 3) begin
        checks++;
        if (gain[0] !== 24'h0C0000) begin failures++; $display("FAIL ramp3_ch0 got=%h exp=0c0000", gain[0]); end
        checks++;
        if (gain[1] !== 24'hF40000) begin failures++; $display("FAIL ramp3_ch1 got=%h exp=f40000", gain[1]); end
        checks++;
        if (gain[3] !== 24'h0C0000) begin failures++; $display("FAIL ramp3_ch3 got=%h exp=0c0000", gain[3]); end
        checks++;
        if (busy !== 4'b1011) begin failures++; $display("FAIL ramp3_busy got=%b exp=1011", busy); end
      end
      if (t == 4) begin
        checks++;
        if (gain[0] !== 24'h100000) begin failures++; $display("FAIL ramp4_ch0 got=%h exp=100000", gain[0]); end
        checks++;
        if (gain[1] !== 24'hF00000) begin failures++; $display("FAIL ramp4_ch1 got=%h exp=f00000", gain[1]); end
        checks++;
        if (gain[2] !== 24'h000000) begin failures++; $display("FAIL ramp4_ch2 got=%h exp=000000", gain[2]); end
        checks++;
        if (busy !== 4'b1000) begin failures++; $display("FAIL ramp4_busy got=%b exp=1000", busy); end
      end
      if (t == 31) begin
        checks++;
        if (gain[3] !== 24'h7C0000) begin failures++; $display("FAIL ramp31_ch3 got=%h exp=7c0000", gain[3]); end
        checks++;
        if (busy !== 4'b1000) begin failures++; $display("FAIL ramp31_busy got=%b exp=1000", busy); end
      end
      if (t == 32) begin
        checks++;
        if (gain[3] !== 24'h7FFFFF) begin failures++; $display("FAIL ramp32_ch3 got=%h exp=7fffff", gain[3]); end
        checks++;
        if (busy !== 4'b0000) begin failures++; $display("FAIL ramp32_busy got=%b exp=0000", busy); end
      end
    end
    checks++;
    if (dones != 32) begin failures++; $display("FAIL ramp_done_count got=%0d exp=32", dones); end
  endtask

  task automatic test_sweep_timing();
    logic [GW-1:0] exp_g;
    logic          exp_d;
    do_reset();
    tgt[0] = 24'h000010; tgt[1] = 24'h000020; tgt[2] = 24'h000030; tgt[3] = 24'h000040;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    checks++;
    if (gain !== '0) begin failures++; $display("FAIL timing_k got=%h exp=0", gain); end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      exp_g = GW'(16 * (i + 1));
      exp_d = (i == N - 1);
      checks++;
      if (gain[i] !== exp_g) begin
        failures++; $display("FAIL timing_land_ch%0d got=%h exp=%h", i, gain[i], exp_g);
      end
      if (i < N - 1) begin
        checks++;
        if (gain[i+1] !== 24'h0) begin
          failures++; $display("FAIL timing_early_ch%0d got=%h exp=000000", i + 1, gain[i+1]);
        end
      end
      checks++;
      if (done !== exp_d) begin failures++; $display("FAIL timing_done%0d got=%b exp=%b", i, done, exp_d); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL timing_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tgt[0] = 24'h000010; tgt[1] = 24'h000020; tgt[2] = 24'h000030; tgt[3] = 24'h000040;
    sample_tick = 1'b1;
    @(negedge clk);            // after edge k
    sample_tick = 1'b0;
    @(negedge clk);            // after k+1
    sample_tick = 1'b1;
    tgt[0] = 24'h000050;
    checks++;
    if (gain[0] !== 24'h000010) begin failures++; $display("FAIL b2b_ch0_first got=%h exp=000010", gain[0]); end
    @(negedge clk);            // after k+2
    sample_tick = 1'b0;
    nclk(2);                   // after k+4
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    checks++;
    if (gain[0] !== 24'h000010) begin failures++; $display("FAIL b2b_ch0_hold got=%h exp=000010", gain[0]); end
    @(negedge clk);            // after k+5
    checks++;
    if (gain[0] !== 24'h000050) begin failures++; $display("FAIL b2b_ch0_second got=%h exp=000050", gain[0]); end
    nclk(3);                   // after k+8
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", done); end
    nclk(4);
  endtask

  task automatic test_overrun();
    sample_tick = 1'b1;
    @(negedge clk);            // after k
    sample_tick = 1'b0;
    @(negedge clk);            // after k+1
    sample_tick = 1'b1;
    @(negedge clk);            // after k+2
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_pending_only got=%b exp=0", overrun); end
    @(negedge clk);            // after k+3
    sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    @(negedge clk);            // after k+4
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL ovr_done got=%b exp=1", done); end
    sample_tick = 1'b1;
    @(negedge clk);            // after k+5
    clr = 1'b1;
    @(negedge clk);            // after k+6
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_clear_collide got=%b exp=1", overrun); end
    sample_tick = 1'b0;
    @(negedge clk);            // after k+7
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    clr = 1'b0;
    nclk(12);
  endtask

  task automatic test_bypass();
    int dones = 0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    bypass = 1'b1;
    tgt[0] = 24'h123456; tgt[1] = 24'h0ABCDE; tgt[2] = 24'hFEDCBA; tgt[3] = 24'h000777;
    @(negedge clk);
    checks++;
    if (gain[0] !== 24'h123456) begin failures++; $display("FAIL byp_ch0 got=%h exp=123456", gain[0]); end
    checks++;
    if (gain[1] !== 24'h0ABCDE) begin failures++; $display("FAIL byp_ch1 got=%h exp=0abcde", gain[1]); end
    checks++;
    if (gain[2] !== 24'hFEDCBA) begin failures++; $display("FAIL byp_ch2 got=%h exp=fedcba", gain[2]); end
    checks++;
    if (gain[3] !== 24'h000777) begin failures++; $display("FAIL byp_ch3 got=%h exp=000777", gain[3]); end
    for (int i = 0; i < 10; i++) begin
      sample_tick = (i % 3) != 2;
      @(negedge clk);
      if (done) dones++;
    end
    sample_tick = 1'b0;
    tgt[0] = 24'h222222;
    @(negedge clk);
    if (done) dones++;
    checks++;
    if (gain[0] !== 24'h222222) begin failures++; $display("FAIL byp_follow got=%h exp=222222", gain[0]); end
    bypass = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL byp_no_sweep got=%0d exp=0", dones); end
    tgt[0] = 24'h222322;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (gain[0] !== 24'h222322) begin failures++; $display("FAIL byp_resume got=%h exp=222322", gain[0]); end
    nclk(3);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL byp_resume_done got=%b exp=1", done); end
    nclk(2);
  endtask

  task automatic test_reset_mid_sweep();
    step = 20'h01000;
    for (int i = 0; i < N; i++) tgt[i] = 24'h100000;
    sample_tick = 1'b1;
    @(negedge clk);            // after k
    @(negedge clk);            // after k+1
    checks++;
    if (gain[0] !== 24'h221322) begin failures++; $display("FAIL rstmid_ch0 got=%h exp=221322", gain[0]); end
    @(negedge clk);            // after k+2: third tick overruns
    sample_tick = 1'b0;
    checks++;
    if (gain[1] !== 24'h0ACCDE) begin failures++; $display("FAIL rstmid_ch1 got=%h exp=0accde", gain[1]); end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL rstmid_ovr_pre got=%b exp=1", overrun); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gain !== '0) begin failures++; $display("FAIL rstmid_gains got=%h exp=0", gain); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (gain[0] !== 24'h001000 || gain[1] !== 24'h0) begin
      failures++; $display("FAIL rstmid_restart0 got=%h/%h exp=001000/000000", gain[0], gain[1]);
    end
    @(negedge clk);
    checks++;
    if (gain[1] !== 24'h001000) begin failures++; $display("FAIL rstmid_restart1 got=%h exp=001000", gain[1]); end
    nclk(2);
    checks++;
    if (gain[3] !== 24'h001000 || done !== 1'b1) begin
      failures++; $display("FAIL rstmid_restart3 got=%h/%b exp=001000/1", gain[3], done);
    end
    nclk(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_sweep_timing();
    test_back_to_back();
    test_overrun();
    test_bypass();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mixer_gain_ramp.md
Name: mixer_gain_ramp

Overview:
- Gain-smoothing controller placed between the configuration registers and the mixer core's per-channel gain inputs.
- Walks each channel's applied gain toward its programmed target by a bounded step once per audio sample, removing zipper noise on gain changes.
- One channel is updated per clock in a round-robin sweep triggered by the sample strobe.
- Reports per-channel ramp status and sample-strobe overruns.

Parameters:
- NR_OF_CHANNELS_P, 4, number of mixer input channels (>=1).
- GAIN_WIDTH_P, 24, width of a gain word; signed two's complement in the mixer's Q format.
- STEP_WIDTH_P, 16, width of the unsigned ramp step; must be <= GAIN_WIDTH_P.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active-low.
- sample_tick  input  1  one-cycle pulse per audio sample (the mixer ingress valid).
- cr_target_gain  input  NR_OF_CHANNELS_P x GAIN_WIDTH_P  programmed target gain per channel, signed.
- cr_ramp_step  input  STEP_WIDTH_P  maximum gain change per channel per sample, unsigned.
- cr_ramp_bypass  input  1  when high, applied gain follows target directly.
- cr_clear_overrun  input  1  pulse; clears sr_tick_overrun.
- mix_channel_gain  output  NR_OF_CHANNELS_P x GAIN_WIDTH_P  applied gain, to mixer channel gain inputs; registered.
- sr_ramp_busy  output  NR_OF_CHANNELS_P  bit i high while mix_channel_gain[i] != cr_target_gain[i] (combinational compare).
- sr_tick_overrun  output  1  sticky; a tick was lost.
- sweep_done  output  1  one-cycle pulse after each completed sweep; registered.

Behaviour:
- Reset (rst_n low, asynchronous) drives:
  - all mix_channel_gain to 0;
  - sweep_done, sr_tick_overrun, pending flag and channel index to 0;
  - FSM to IDLE.
- sr_ramp_busy is not registered; after reset it reflects 0 != target.
- FSM states: IDLE, SWEEP.
- IDLE:
  - sample_tick high at edge k -> SWEEP, idx=0.
  - With no tick, the FSM stays in IDLE.
- SWEEP (channel update):
  - At each edge, channel idx is updated, then idx increments.
  - Channel i is updated at edge k+1+i.
  - Last channel is updated at edge k+NR_OF_CHANNELS_P.
  - At that same edge, sweep_done pulses high for one cycle.
- End of SWEEP:
  - If pending is set, or sample_tick is high in that last cycle: restart SWEEP with idx=0, clear pending.
  - Otherwise go to IDLE.
- Update rule for channel i. Compute d = target - current in GAIN_WIDTH_P+1 bits signed.
  - If |d| <= step: current = target.
  - Else if d > 0: current += step.
  - Else: current -= step.
  - Step is zero-extended.
  - No overshoot and no wrap: the result always lies between the old value and the target, inclusive.
- The target is sampled at the channel's own update edge. A target change mid-sweep applies to channels not yet visited in this sweep, and to visited channels from the next sweep.
- cr_ramp_step = 0: gains hold. Sweeps still run and sweep_done still pulses.
- Tick during SWEEP (not in the last cycle):
  - If pending=0: set pending.
  - If pending=1: tick lost, sr_tick_overrun set to 1.
- Overrun clear and set precedence:
  - cr_clear_overrun clears sr_tick_overrun.
  - A simultaneous overrun event wins: the flag stays 1.
- Bypass (cr_ramp_bypass high):
  - Every edge, all mix_channel_gain load cr_target_gain.
  - FSM forced to IDLE; pending and idx cleared; sweep_done held 0; ticks ignored.
  - On deassertion, normal operation resumes from IDLE. The first tick after deassertion starts a sweep.
- NR_OF_CHANNELS_P = 1: a sweep is a single cycle. A back-to-back tick in that cycle restarts immediately.
- Reset asserted mid-sweep: immediate return to reset state. Partially-ramped gains are lost and become 0.

Test Plan:
- Reset, then targets {0x100000, -0x100000, 0, 0x7FFFFF}, step 0x40000, periodic tick every 16 cycles:
  - ch0 reaches 0x100000 after 4 ticks.
  - ch1 reaches 0xF00000 after 4 ticks.
  - ch3 reaches 0x7FFFFF after 32 ticks, with the final step partial.
  - sr_ramp_busy clears per channel as each reaches target.
- Single tick at edge k, N=4: gain[i] changes exactly at edge k+1+i; sweep_done high for the cycle after edge k+4.
- Tick at k and at k+2:
  - A second sweep starts at k+5; no overrun.
  - An additional tick at k+3 sets sr_tick_overrun.
  - cr_clear_overrun clears it, except in a cycle with a simultaneous overrun.
- Target 0x000010, current 0, step 0x40000: ch lands exactly on 0x000010 in one sweep, with no overshoot.
- Bypass asserted mid-sweep with target 0x123456: gain = 0x123456 on the next edge, FSM in IDLE, and ticks during bypass produce no sweep_done.
- rst_n pulsed low during a sweep: all gains immediately 0, flags cleared, and the next tick starts a clean sweep from idx 0.
